// File: rtl/mux_nto1_pipe.sv
// N-input operand-select mux: 1-cycle registered output, valid/ready with a 2-entry skid; in_ready is registered (no out_ready path).
// Optional saturating out-of-range counter on err_count when MUX_NTO1_PIPE_SEL_ERR_CNT_EN is defined.
module mux_nto1_pipe #(
  parameter int              WIDTH       = 32,
  parameter int              NUM_IN      = 5,
  parameter int              SEL_W       = 3,
  parameter logic [WIDTH-1:0] DEFAULT_VAL = '0
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_sel_err,
  output logic                    out_valid,
  input  logic                    out_ready
`ifdef MUX_NTO1_PIPE_SEL_ERR_CNT_EN
  ,
  output logic [15:0]             err_count
`endif
);

  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_FULL} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   main_dat_q, main_dat_d;
  logic               main_err_q, main_err_d;
  logic [WIDTH-1:0]   skid_dat_q, skid_dat_d;
  logic               skid_err_q, skid_err_d;
  logic               in_rdy_q, in_rdy_d;

  logic [31:0]        sel_ext;
  logic [WIDTH-1:0]   sel_dat;
  logic               sel_err;
  logic               accept;
  logic               xfer;

  assign sel_ext = 32'(sel);

  // Any select that matches no input falls through to DEFAULT_VAL with the error flag.
  always_comb begin
    sel_dat = DEFAULT_VAL;
    sel_err = 1'b1;
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel_ext == 32'(k)) begin
        sel_dat = in_data[k*WIDTH +: WIDTH];
        sel_err = 1'b0;
      end
    end
  end

  assign accept = in_valid && in_rdy_q;
  assign xfer   = (state_q != ST_EMPTY) && out_ready;

  always_comb begin
    state_d    = state_q;
    main_dat_d = main_dat_q;
    main_err_d = main_err_q;
    skid_dat_d = skid_dat_q;
    skid_err_d = skid_err_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d    = ST_ONE;
          main_dat_d = sel_dat;
          main_err_d = sel_err;
        end
      end
      ST_ONE: begin
        if (accept && xfer) begin
          main_dat_d = sel_dat;
          main_err_d = sel_err;
        end else if (accept) begin
          state_d    = ST_FULL;
          skid_dat_d = sel_dat;
          skid_err_d = sel_err;
        end else if (xfer) begin
          state_d    = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (xfer) begin
          state_d    = ST_ONE;
          main_dat_d = skid_dat_q;
          main_err_d = skid_err_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  assign in_rdy_d = (state_d != ST_FULL);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q    <= ST_EMPTY;
      main_dat_q <= '0;
      main_err_q <= 1'b0;
      skid_dat_q <= '0;
      skid_err_q <= 1'b0;
      in_rdy_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      main_dat_q <= main_dat_d;
      main_err_q <= main_err_d;
      skid_dat_q <= skid_dat_d;
      skid_err_q <= skid_err_d;
      in_rdy_q   <= in_rdy_d;
    end
  end

  assign in_ready    = in_rdy_q;
  assign out_valid   = (state_q != ST_EMPTY);
  assign out_data    = main_dat_q;
  assign out_sel_err = main_err_q;

`ifdef MUX_NTO1_PIPE_SEL_ERR_CNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  // Counted at accept so a stalled beat is not missed or double counted.
  assign err_cnt_d = (accept && sel_err && (err_cnt_q != 16'hFFFF)) ? err_cnt_q + 16'd1 : err_cnt_q;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_count = err_cnt_q;
`endif

endmodule
